// File: rtl/cpld_bus_system_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpld_bus_system_pkg
// Purpose  : Shared constants and types for the CPLD AVR/SNES SRAM bridge.
//            Holds the bus widths, the avr_ctrl bit map and the bus FSM
//            state encoding.
// Revision : 1.0  initial release
// ============================================================================
package cpld_bus_system_pkg;

  // Bus widths
  localparam int ADDR_W = 21;
  localparam int DATA_W = 8;

  // avr_ctrl bit map (bits 2:1 are reserved and ignored)
  localparam int CTRL_W             = 3;
  localparam int CTRL_SNES_MODE_BIT = 0;

  // AVR<->SRAM bus sequencer states
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RD_SETUP   = 3'd1,
    ST_RD_LATCH   = 3'd2,
    ST_WR_LATCH   = 3'd3,
    ST_WR_STROBE  = 3'd4,
    ST_WR_RELEASE = 3'd5
  } bus_state_t;

endpackage
`default_nettype wire

// File: rtl/cpld_bus_system_addr_sreg.sv
`default_nettype none
// ============================================================================
// Module   : cpld_bus_system_addr_sreg
// Purpose  : SRAM address register. Loaded serially MSB first while
//            shift_en is high; otherwise advanced by one on every falling
//            edge of counter_n (wrapping at the top of the address space).
// Ports    : clk, rst_n  in  clock / async active-low reset
//            shift_en    in  shift shift_bit into the LSB
//            shift_bit   in  serial address bit
//            counter_n   in  increment strobe, acts on 1->0 transition
//            addr        out current address
// Revision : 1.0  initial release
// ============================================================================
module cpld_bus_system_addr_sreg
  import cpld_bus_system_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic              shift_bit,
  input  logic              counter_n,
  output logic [ADDR_W-1:0] addr
);

  // Previous sample of counter_n; resets high so an idle-high strobe
  // produces no spurious increment when reset is released.
  logic counter_n_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr        <= '0;
      counter_n_q <= 1'b1;
    end else begin
      counter_n_q <= counter_n;
      // A falling edge coinciding with a shift is dropped: shift wins.
      if (shift_en) begin
        addr <= {addr[ADDR_W-2:0], shift_bit};
      end else if (counter_n_q && !counter_n) begin
        addr <= addr + ADDR_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpld_bus_system_bus_fsm.sv
`default_nettype none
// ============================================================================
// Module   : cpld_bus_system_bus_fsm
// Purpose  : AVR<->SRAM bus sequencer with a one-byte data buffer.
//            Read : RD_SETUP -> RD_LATCH (buffer <= SRAM) -> IDLE
//            Write: WR_LATCH (buffer <= AVR) -> WR_STROBE -> WR_RELEASE -> IDLE
//            A held request simply restarts the sequence from IDLE.
// Ports    : clk, rst_n      in  clock / async active-low reset
//            shift_en        in  address shift in progress, forces IDLE
//            snes_mode       in  SNES owns the SRAM, forces IDLE
//            rd_req, wr_req  in  decoded AVR requests
//            avr_data_in     in  AVR data bus sample
//            sram_data_in    in  SRAM data bus sample
//            buffer          out data byte buffer
//            ce_n/oe_n/we_n  out registered SRAM strobes
//            sram_drive      out bridge drives the SRAM data bus
// Revision : 1.0  initial release
// ============================================================================
module cpld_bus_system_bus_fsm
  import cpld_bus_system_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic              snes_mode,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] avr_data_in,
  input  logic [DATA_W-1:0] sram_data_in,
  output logic [DATA_W-1:0] buffer,
  output logic              ce_n,
  output logic              oe_n,
  output logic              we_n,
  output logic              sram_drive
);

  bus_state_t state, state_nxt;
  logic       ce_n_nxt, oe_n_nxt, we_n_nxt;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (rd_req) begin
          state_nxt = ST_RD_SETUP;
        end else if (wr_req) begin
          state_nxt = ST_WR_LATCH;
        end
      end
      ST_RD_SETUP:   state_nxt = ST_RD_LATCH;
      ST_RD_LATCH:   state_nxt = ST_IDLE;
      ST_WR_LATCH:   state_nxt = ST_WR_STROBE;
      ST_WR_STROBE:  state_nxt = ST_WR_RELEASE;
      ST_WR_RELEASE: state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
    if (shift_en || snes_mode) begin
      state_nxt = ST_IDLE;
    end

    // Strobes are decoded from the next state and registered, so they
    // change cleanly with the state register and never glitch.
    ce_n_nxt = !(state_nxt == ST_RD_SETUP  || state_nxt == ST_RD_LATCH ||
                 state_nxt == ST_WR_STROBE || state_nxt == ST_WR_RELEASE);
    oe_n_nxt = !(state_nxt == ST_RD_SETUP  || state_nxt == ST_RD_LATCH);
    we_n_nxt = !(state_nxt == ST_WR_STROBE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      buffer <= '0;
      ce_n   <= 1'b1;
      oe_n   <= 1'b1;
      we_n   <= 1'b1;
    end else begin
      state <= state_nxt;
      ce_n  <= ce_n_nxt;
      oe_n  <= oe_n_nxt;
      we_n  <= we_n_nxt;
      if (state == ST_RD_LATCH) begin
        buffer <= sram_data_in;
      end else if (state == ST_WR_LATCH) begin
        buffer <= avr_data_in;
      end
    end
  end

  assign sram_drive = (state == ST_WR_STROBE) || (state == ST_WR_RELEASE);

endmodule
`default_nettype wire

// File: rtl/cpld_bus_system_cmd_decode.sv
`default_nettype none
// ============================================================================
// Module   : cpld_bus_system_cmd_decode
// Purpose  : Decodes the AVR control pins into mode and request qualifiers.
// Ports    : ctrl        in  avr_ctrl command word (bit0 = snes_mode)
//            sreg_en_n   in  shift enable, active low
//            oe_n, we_n  in  AVR read / write requests, active low
//            snes_mode   out SNES owns the SRAM
//            shift_en    out address shift active
//            rd_req      out clean AVR read request (no shift, no write)
//            wr_req      out clean AVR write request (no shift, no read)
//            avr_drive   out bridge may drive avr_data
// Revision : 1.0  initial release
// ============================================================================
module cpld_bus_system_cmd_decode
  import cpld_bus_system_pkg::*;
(
  input  logic [CTRL_W-1:0] ctrl,
  input  logic              sreg_en_n,
  input  logic              oe_n,
  input  logic              we_n,
  output logic              snes_mode,
  output logic              shift_en,
  output logic              rd_req,
  output logic              wr_req,
  output logic              avr_drive
);

  // Reserved command bits are accepted but have no effect.
  logic reserved_unused;
  assign reserved_unused = ^ctrl[CTRL_W-1:1];

  assign snes_mode = ctrl[CTRL_SNES_MODE_BIT];
  assign shift_en  = ~sreg_en_n;
  assign rd_req    = sreg_en_n & ~oe_n &  we_n;
  assign wr_req    = sreg_en_n &  oe_n & ~we_n;
  assign avr_drive = rd_req & ~snes_mode;

endmodule
`default_nettype wire

// File: rtl/cpld_bus_system.sv
`default_nettype none
// ============================================================================
// Module   : cpld_bus_system
// Purpose  : CPLD top. AVR-to-SRAM bridge with a serially loaded address
//            counter, and a combinational SNES passthrough that takes over
//            the SRAM when avr_ctrl[0] is set. This level only muxes the
//            address/strobes and drives the three tristate data buses.
// Ports    : avr_clk, avr_reset_n        clock / async active-low reset
//            avr_sreg_en_n, avr_si       serial address load
//            avr_counter_n               address increment strobe
//            avr_oe_n, avr_we_n          AVR read / write requests
//            avr_ctrl                    command (bit0 = snes_mode)
//            avr_data                    AVR data bus (inout)
//            sram_addr, sram_data        SRAM address / data (inout)
//            sram_ce_n/oe_n/we_n         SRAM strobes
//            snes_addr, snes_data        SNES address / data (inout)
// Revision : 1.0  initial release
// ============================================================================
module cpld_bus_system
  import cpld_bus_system_pkg::*;
(
  input  logic              avr_clk,
  input  logic              avr_reset_n,
  input  logic              avr_sreg_en_n,
  input  logic              avr_si,
  input  logic              avr_counter_n,
  input  logic              avr_oe_n,
  input  logic              avr_we_n,
  input  logic [CTRL_W-1:0] avr_ctrl,
  inout  wire  [DATA_W-1:0] avr_data,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  input  logic [ADDR_W-1:0] snes_addr,
  inout  wire  [DATA_W-1:0] snes_data
);

  logic              snes_mode, shift_en, rd_req, wr_req, avr_drive;
  logic [ADDR_W-1:0] avr_addr;
  logic [DATA_W-1:0] buffer;
  logic              fsm_ce_n, fsm_oe_n, fsm_we_n, sram_drive;

  cpld_bus_system_cmd_decode u_cmd_decode (
    .ctrl      (avr_ctrl),
    .sreg_en_n (avr_sreg_en_n),
    .oe_n      (avr_oe_n),
    .we_n      (avr_we_n),
    .snes_mode (snes_mode),
    .shift_en  (shift_en),
    .rd_req    (rd_req),
    .wr_req    (wr_req),
    .avr_drive (avr_drive)
  );

  cpld_bus_system_addr_sreg u_addr_sreg (
    .clk       (avr_clk),
    .rst_n     (avr_reset_n),
    .shift_en  (shift_en),
    .shift_bit (avr_si),
    .counter_n (avr_counter_n),
    .addr      (avr_addr)
  );

  cpld_bus_system_bus_fsm u_bus_fsm (
    .clk          (avr_clk),
    .rst_n        (avr_reset_n),
    .shift_en     (shift_en),
    .snes_mode    (snes_mode),
    .rd_req       (rd_req),
    .wr_req       (wr_req),
    .avr_data_in  (avr_data),
    .sram_data_in (sram_data),
    .buffer       (buffer),
    .ce_n         (fsm_ce_n),
    .oe_n         (fsm_oe_n),
    .we_n         (fsm_we_n),
    .sram_drive   (sram_drive)
  );

  // Mode switch is combinational: SNES gets a permanently enabled read port.
  assign sram_addr = snes_mode ? snes_addr : avr_addr;
  assign sram_ce_n = snes_mode ? 1'b0 : fsm_ce_n;
  assign sram_oe_n = snes_mode ? 1'b0 : fsm_oe_n;
  assign sram_we_n = snes_mode ? 1'b1 : fsm_we_n;

  // The write-phase drive is also gated by the mode so that entering SNES
  // mode mid-write never fights the SRAM output.
  assign avr_data  = avr_drive                 ? buffer    : 'z;
  assign sram_data = (sram_drive && !snes_mode) ? buffer    : 'z;
  assign snes_data = snes_mode                 ? sram_data : 'z;

endmodule
`default_nettype wire

// File: tb/tb_cpld_bus_system.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpld_bus_system
// Purpose  : Scoreboard bench for cpld_bus_system. Stimulus tasks push
//            expected responses into queues; a negedge monitor pops and
//            compares them against the DUT pins.
// Revision : 1.0  initial release
// ============================================================================
module tb_cpld_bus_system;

  localparam int          AW   = 21;
  localparam logic [20:0] MASK = 21'h1FFFFF;

  localparam int K_ADDR   = 0;  // sram_addr
  localparam int K_STROBE = 1;  // {ce_n, oe_n, we_n}
  localparam int K_AVR    = 2;  // avr_data value
  localparam int K_SRAM   = 3;  // sram_data value
  localparam int K_SNES   = 4;  // snes_data value

  logic          avr_clk = 1'b0;
  logic          avr_reset_n;
  logic          avr_sreg_en_n, avr_si, avr_counter_n, avr_oe_n, avr_we_n;
  logic [2:0]    avr_ctrl;
  logic [AW-1:0] snes_addr;
  logic [AW-1:0] sram_addr;
  logic          sram_ce_n, sram_oe_n, sram_we_n;
  wire  [7:0]    avr_data, sram_data, snes_data;

  // Bench-side bus drivers. The "probe" drivers put 0x00 on a bus that the
  // DUT should leave floating; any DUT drive shows up as a different value.
  logic       avr_drv_en, avr_probe_en, sram_probe_en, snes_probe_en;
  logic [7:0] avr_drv_val, sram_val;

  assign avr_data  = avr_drv_en ? avr_drv_val : (avr_probe_en ? 8'h00 : 8'hzz);
  // Simple SRAM: presents sram_val whenever it is read-enabled.
  assign sram_data = (!sram_ce_n && !sram_oe_n && sram_we_n) ? sram_val :
                     (sram_probe_en ? 8'h00 : 8'hzz);
  assign snes_data = snes_probe_en ? 8'h00 : 8'hzz;

  cpld_bus_system dut (
    .avr_clk       (avr_clk),
    .avr_reset_n   (avr_reset_n),
    .avr_sreg_en_n (avr_sreg_en_n),
    .avr_si        (avr_si),
    .avr_counter_n (avr_counter_n),
    .avr_oe_n      (avr_oe_n),
    .avr_we_n      (avr_we_n),
    .avr_ctrl      (avr_ctrl),
    .avr_data      (avr_data),
    .sram_addr     (sram_addr),
    .sram_data     (sram_data),
    .sram_ce_n     (sram_ce_n),
    .sram_oe_n     (sram_oe_n),
    .sram_we_n     (sram_we_n),
    .snes_addr     (snes_addr),
    .snes_data     (snes_data)
  );

  always #5 avr_clk = ~avr_clk;

  int cyc = 0;
  always @(posedge avr_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int kind; logic [31:0] exp; }             ck_t;
  typedef struct { logic [7:0] data; int deadline; }          rd_t;
  typedef struct { logic [20:0] addr; logic [7:0] data; }     wr_t;
  ck_t ck_q[$];
  rd_t rd_q[$];
  wr_t wr_q[$];

  // Reference model state: where the address register should be.
  logic [20:0] exp_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push_ck(input int kind, input logic [31:0] exp);
    ck_t c;
    c.kind = kind;
    c.exp  = exp;
    ck_q.push_back(c);
  endtask

  task automatic push_rd(input logic [7:0] v);
    rd_t r;
    r.data     = v;
    r.deadline = cyc + 3;
    rd_q.push_back(r);
  endtask

  task automatic push_wr(input logic [20:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wr_q.push_back(w);
  endtask

  // ---------------------------------------------------------------- monitor
  always @(negedge avr_clk) begin : monitor
    ck_t c;
    wr_t w;
    while (ck_q.size() != 0) begin
      c = ck_q.pop_front();
      case (c.kind)
        K_ADDR:   check("sram_addr", 32'(sram_addr), c.exp);
        K_STROBE: check("strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n}), c.exp);
        K_AVR:    check("avr_data", 32'(avr_data), c.exp);
        K_SRAM:   check("sram_data", 32'(sram_data), c.exp);
        default:  check("snes_data", 32'(snes_data), c.exp);
      endcase
    end
    if (rd_q.size() != 0) begin
      if (avr_data === rd_q[0].data) begin
        check("read_data", 32'(avr_data), 32'(rd_q[0].data));
        void'(rd_q.pop_front());
      end else if (cyc >= rd_q[0].deadline) begin
        check("read_latency", 32'(avr_data), 32'(rd_q[0].data));
        void'(rd_q.pop_front());
      end
    end
    if (sram_we_n === 1'b0) begin
      if (wr_q.size() == 0) begin
        check("unexpected_we_pulse", 32'(sram_we_n), 32'd1);
      end else begin
        w = wr_q.pop_front();
        check("write_addr", 32'(sram_addr), 32'(w.addr));
        check("write_data", 32'(sram_data), 32'(w.data));
        check("write_ce_n", 32'(sram_ce_n), 32'd0);
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic step(input int n);
    repeat (n) begin
      @(posedge avr_clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (rd_q.size() != 0 || wr_q.size() != 0); i++) step(1);
    check("drain_rd_pending", 32'(rd_q.size()), 32'd0);
    check("drain_wr_pending", 32'(wr_q.size()), 32'd0);
    rd_q.delete();
    wr_q.delete();
  endtask

  task automatic probe_avr_z();
    avr_probe_en = 1'b1;
    push_ck(K_AVR, 32'h00);
    step(1);
    avr_probe_en = 1'b0;
  endtask

  // Shift a word in MSB first; optionally drop counter_n during bit cnt_at
  // to confirm the shift takes priority over the increment.
  task automatic shift_word(input logic [20:0] w, input int cnt_at);
    for (int i = AW - 1; i >= 0; i--) begin
      avr_sreg_en_n = 1'b0;
      avr_si        = w[i];
      avr_counter_n = (i == cnt_at) ? 1'b0 : 1'b1;
      step(1);
    end
    avr_sreg_en_n = 1'b1;
    avr_counter_n = 1'b1;
    exp_addr      = w;
    push_ck(K_ADDR, 32'(exp_addr));
    step(1);
  endtask

  task automatic pulse_counter(input int low_cycles);
    avr_counter_n = 1'b0;
    step(low_cycles);
    avr_counter_n = 1'b1;
    step(1);
    exp_addr = (exp_addr + 21'd1) & MASK;
    push_ck(K_ADDR, 32'(exp_addr));
    step(1);
  endtask

  // Held read; the SRAM content changes once mid-request.
  task automatic do_read(input logic [7:0] v1, input logic [7:0] v2, input bit chk_strobe);
    sram_val = v1;
    avr_oe_n = 1'b0;
    push_rd(v1);
    step(1);
    if (chk_strobe) push_ck(K_STROBE, 32'b001);
    for (int i = 0; i < 8 && rd_q.size() != 0; i++) step(1);
    sram_val = v2;
    push_rd(v2);
    drain();
    avr_oe_n = 1'b1;
    step(3);
    push_ck(K_STROBE, 32'b111);
    step(1);
  endtask

  task automatic do_write(input logic [7:0] d);
    avr_drv_val = d;
    avr_drv_en  = 1'b1;
    avr_we_n    = 1'b0;
    push_wr(exp_addr, d);
    step(1);
    avr_we_n = 1'b1;    // dropped mid-sequence: exactly one pulse expected
    step(1);
    avr_drv_en = 1'b0;
    step(3);
    drain();
    sram_probe_en = 1'b1;
    push_ck(K_SRAM, 32'h00);
    push_ck(K_STROBE, 32'b111);
    step(1);
    sram_probe_en = 1'b0;
  endtask

  task automatic snes_peek(input logic [20:0] a, input logic [7:0] v);
    avr_ctrl     = 3'b001;
    snes_addr    = a;
    sram_val     = v;
    avr_oe_n     = 1'b0;     // an AVR read request must be ignored here
    avr_probe_en = 1'b1;
    push_ck(K_ADDR, 32'(a));
    push_ck(K_STROBE, 32'b001);
    push_ck(K_SNES, 32'(v));
    push_ck(K_AVR, 32'h00);
    step(1);
    snes_addr = (a ^ 21'h0F0F0F) & MASK;
    push_ck(K_ADDR, 32'(snes_addr));
    step(1);
    avr_oe_n      = 1'b1;
    avr_probe_en  = 1'b0;
    avr_ctrl      = 3'b000;
    snes_probe_en = 1'b1;
    push_ck(K_ADDR, 32'(exp_addr));
    push_ck(K_SNES, 32'h00);
    step(1);
    snes_probe_en = 1'b0;
    push_ck(K_STROBE, 32'b111);
    step(1);
  endtask

  initial begin
    avr_reset_n   = 1'b0;
    avr_sreg_en_n = 1'b1;
    avr_si        = 1'b0;
    avr_counter_n = 1'b1;
    avr_oe_n      = 1'b1;
    avr_we_n      = 1'b1;
    avr_ctrl      = 3'b000;
    snes_addr     = '0;
    avr_drv_en    = 1'b0;
    avr_drv_val   = 8'h00;
    avr_probe_en  = 1'b0;
    sram_probe_en = 1'b0;
    snes_probe_en = 1'b0;
    sram_val      = 8'h00;
    exp_addr      = '0;

    // Reset state
    step(3);
    avr_probe_en  = 1'b1;
    sram_probe_en = 1'b1;
    snes_probe_en = 1'b1;
    push_ck(K_ADDR, 32'h0);
    push_ck(K_STROBE, 32'b111);
    push_ck(K_AVR, 32'h00);
    push_ck(K_SRAM, 32'h00);
    push_ck(K_SNES, 32'h00);
    step(1);
    avr_probe_en  = 1'b0;
    sram_probe_en = 1'b0;
    snes_probe_en = 1'b0;
    avr_reset_n   = 1'b1;
    step(2);

    // Directed scenarios
    shift_word(21'h004CCF, 7);
    do_read(8'hAA, 8'hBB, 1'b1);
    probe_avr_z();
    do_write(8'hEE);
    pulse_counter(2);                 // 0x004CCF -> 0x004CD0
    shift_word(21'h1FFFFF, -1);
    pulse_counter(1);                 // wrap to 0
    snes_peek(21'h123456 & MASK, 8'h5A);

    // Randomized traffic; reserved avr_ctrl bits toggle freely in AVR mode
    for (int n = 0; n < 40; n++) begin
      avr_ctrl = 3'($urandom_range(0, 3)) << 1;
      case ($urandom_range(0, 4))
        0: shift_word(21'($urandom) & MASK, $urandom_range(0, 30));
        1: do_read(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 1'b0);
        2: do_write(8'($urandom));
        3: pulse_counter($urandom_range(1, 3));
        default: snes_peek(21'($urandom) & MASK, 8'($urandom));
      endcase
    end
    avr_ctrl = 3'b000;
    step(2);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
